// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encoding and opcode constants for the serial adder
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// rtl/serial_add_ctrl_fa.sv - dataflow 1-bit full adder shared by the serial sequencer
module FA_df (
  output logic s,
  output logic cout,
  input  logic x,
  input  logic y,
  input  logic cin
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer, LSB first, one FA per clock
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;

  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted_result;

  FA_df u_fa (
    .s    (w_s),
    .cout (w_cout),
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .cin  (r_carry)
  );

  assign w_last           = (r_cnt == CW'(WIDTH - 1));
  assign w_shifted_result = {w_s, r_result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtraction is a + ~b + 1: b is inverted at load and the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= (op == OP_SUB) ? ~b : b;
            r_carry <= op;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_result <= w_shifted_result;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_overflow  <= r_carry ^ w_cout;
            r_carry_out <= w_cout;
            r_zero      <= (w_shifted_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept at E0, then expect done only after edge E8, then idle again after E9.
  task automatic run_op(input string tag, input logic o, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] er, input logic ec, input logic ev, input logic ez);
    start = 1'b1; op = o; a = xa; b = xb;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
    for (int k = 1; k <= WIDTH; k++) begin
      step();
      if (k < WIDTH) begin
        chk({tag, " done_early"}, done, 1'b0);
      end
    end
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " result"}, result, er);
    chk({tag, " carry_out"}, carry_out, ec);
    chk({tag, " overflow"}, overflow, ev);
    chk({tag, " zero"}, zero, ez);
    step();
    chk({tag, " done_width"}, done, 1'b0);
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " result_hold"}, result, er);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 8'h00);
    chk("reset flags", {carry_out, overflow, zero}, 3'b000);
    rst = 1'b0;
    step();

    run_op("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("sub_05_05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("sub_03_05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

    // start held high through RUN/DONE: ignored until the IDLE edge after DONE.
    start = 1'b1; op = 1'b0; a = 8'h10; b = 8'h20;
    step();
    a = 8'hAA; b = 8'h55;
    for (int k = 1; k <= WIDTH; k++) begin
      step();
      if (k < WIDTH) begin
        chk("hold done_early", done, 1'b0);
        chk("hold busy", busy, 1'b1);
      end
    end
    chk("hold done", done, 1'b1);
    chk("hold result", result, 8'h30);
    step();
    chk("hold idle busy", busy, 1'b0);
    chk("hold idle done", done, 1'b0);
    step();
    chk("hold second accept", busy, 1'b1);
    start = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      step();
      if (k < WIDTH) begin
        chk("hold2 done_early", done, 1'b0);
      end
    end
    chk("hold2 done", done, 1'b1);
    chk("hold2 result", result, 8'hFF);
    chk("hold2 flags", {carry_out, overflow, zero}, 3'b000);
    step();

    // Abort mid-RUN: reset after the third RUN edge.
    start = 1'b1; op = 1'b0; a = 8'h7F; b = 8'h01;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort result", result, 8'h00);
    chk("abort flags", {carry_out, overflow, zero}, 3'b000);
    rst = 1'b0;
    for (int k = 0; k < WIDTH + 2; k++) begin
      step();
      chk("abort no_done", done, 1'b0);
    end

    run_op("add_02_03", 1'b0, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
